// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master sram-like request arbiter, one outstanding transaction
// Optional macro ARB_STARVE_GUARD_EN: forces an inst grant after STARVE_LIMIT consecutive data grants.
module sram_req_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   owner, owner_nx;     // 0 = inst, 1 = data
    logic   any_req;
    logic   sel_data;            // IDLE-time choice
    logic   owner_req;
    logic   fields_en;
    logic   fields_sel;

    assign any_req   = inst_req | data_req;
    assign owner_req = owner ? data_req : inst_req;

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;
    logic             force_inst;

    assign force_inst = inst_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign sel_data   = data_req && !force_inst;

    // Counts back-to-back data grants that bypassed a waiting inst request.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (any_req && sel_data && inst_req)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end
`else
    assign sel_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        mem_req      = 1'b0;
        fields_en    = 1'b0;
        fields_sel   = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_rdata   = 32'h0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    mem_req    = 1'b1;
                    fields_en  = 1'b1;
                    fields_sel = sel_data;
                    if (sel_data)
                        data_addr_ok = mem_addr_ok;
                    else
                        inst_addr_ok = mem_addr_ok;
                    owner_nx = sel_data;
                    state_nx = mem_addr_ok ? WAIT_DATA : ADDR;
                end
            end

            // Grant is locked to owner; a higher-priority request waits.
            ADDR: begin
                if (owner_req) begin
                    mem_req    = 1'b1;
                    fields_en  = 1'b1;
                    fields_sel = owner;
                    if (owner)
                        data_addr_ok = mem_addr_ok;
                    else
                        inst_addr_ok = mem_addr_ok;
                    if (mem_addr_ok)
                        state_nx = WAIT_DATA;
                end else begin
                    state_nx = IDLE;
                end
            end

            WAIT_DATA: begin
                if (mem_data_ok) begin
                    if (owner) begin
                        data_data_ok = 1'b1;
                        data_rdata   = mem_rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_rdata;
                    end
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        if (fields_en) begin
            if (fields_sel) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wstrb = data_wstrb;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wstrb = inst_wstrb;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed and random checks of sram_req_arbiter against a transaction model
module tb_sram_req_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_busy;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    sram_req_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction model: who holds the port, whether the address phase is done,
    // and how many data grants in a row have bypassed a waiting inst request.
    int m_lock    = -1;   // master holding an unaccepted request, -1 none
    bit m_out     = 0;    // address accepted, response pending
    int m_owner   = 0;
    int m_streak  = 0;
    int grants[$];

    logic        e_mem_req, e_mem_wr, e_busy;
    logic [1:0]  e_mem_size;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic [3:0]  e_mem_wstrb;
    logic        e_aok[2], e_dok[2];
    logic [31:0] e_rdata[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic req_of(input int m);
        return (m == 1) ? data_req : inst_req;
    endfunction

    function automatic int pick();
        if (!inst_req && !data_req) return -1;
`ifdef ARB_STARVE_GUARD_EN
        if (inst_req && m_streak >= STARVE_LIMIT) return 0;
`endif
        return data_req ? 1 : 0;
    endfunction

    task automatic compute_expected();
        int who;
        e_mem_req = 0; e_mem_wr = 0; e_mem_size = 0; e_mem_addr = 0; e_mem_wstrb = 0; e_mem_wdata = 0;
        for (int i = 0; i < 2; i++) begin
            e_aok[i] = 0; e_dok[i] = 0; e_rdata[i] = 0;
        end
        e_busy = m_out || (m_lock >= 0);
        if (m_out) begin
            if (mem_data_ok) begin
                e_dok[m_owner]   = 1;
                e_rdata[m_owner] = mem_rdata;
            end
        end else begin
            who = (m_lock >= 0) ? (req_of(m_lock) ? m_lock : -1) : pick();
            if (who >= 0) begin
                e_mem_req = 1;
                e_aok[who] = mem_addr_ok;
                if (who == 1) begin
                    e_mem_wr = data_wr; e_mem_size = data_size; e_mem_addr = data_addr;
                    e_mem_wstrb = data_wstrb; e_mem_wdata = data_wdata;
                end else begin
                    e_mem_wr = inst_wr; e_mem_size = inst_size; e_mem_addr = inst_addr;
                    e_mem_wstrb = inst_wstrb; e_mem_wdata = inst_wdata;
                end
            end
        end
    endtask

    task automatic update_model();
        int who;
        if (reset) begin
            m_out = 0; m_lock = -1; m_streak = 0; m_owner = 0;
        end else if (m_out) begin
            if (mem_data_ok) m_out = 0;
        end else if (m_lock >= 0) begin
            if (!req_of(m_lock)) begin
                m_lock = -1;
            end else if (mem_addr_ok) begin
                m_owner = m_lock; m_lock = -1; m_out = 1;
            end
        end else begin
            who = pick();
            m_streak = (who == 1 && inst_req) ? m_streak + 1 : 0;
            if (who >= 0) begin
                m_owner = who;
                if (mem_addr_ok) m_out = 1;
                else m_lock = who;
            end
        end
    endtask

    // Inputs are stable from the preceding negedge; check mid-cycle, then advance.
    task automatic cycle();
        #1;
        compute_expected();
        check("mem_ctl", {24'h0, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr},
                         {24'h0, e_mem_req, e_mem_wr, e_mem_size, e_mem_wstrb, e_mem_addr});
        check("mem_wdata", {32'h0, mem_wdata}, {32'h0, e_mem_wdata});
        check("inst_resp", {30'h0, inst_addr_ok, inst_data_ok, inst_rdata}, {30'h0, e_aok[0], e_dok[0], e_rdata[0]});
        check("data_resp", {30'h0, data_addr_ok, data_data_ok, data_rdata}, {30'h0, e_aok[1], e_dok[1], e_rdata[1]});
        check("arb_busy", {63'h0, arb_busy}, {63'h0, e_busy});
        if (inst_addr_ok) grants.push_back(0);
        if (data_addr_ok) grants.push_back(1);
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok, input logic [31:0] rd);
        inst_req = ir; data_req = dr; mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    endtask

    int exp_g[6];

    initial begin
        reset = 1;
        drive(0, 0, 0, 0, 0);
        inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000; inst_wstrb = 4'hF; inst_wdata = 32'h0;
        data_wr = 0; data_size = 2; data_addr = 32'h0000_1000; data_wstrb = 4'hF; data_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_busy", {63'h0, arb_busy}, 64'h0);
        check("reset_mem_req", {63'h0, mem_req}, 64'h0);
        cycle();
        reset = 0;
        cycle();

        // Data read, response two cycles after the address
        drive(0, 1, 1, 0, 0);
        #1;
        check("t1_data_addr_ok", {63'h0, data_addr_ok}, 64'h1);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        #1;
        check("t1_data_rdata", {32'h0, data_rdata}, {32'h0, 32'hDEAD_BEEF});
        check("t1_inst_quiet", {62'h0, inst_addr_ok, inst_data_ok}, 64'h0);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();

        // Simultaneous requests: data first, then inst
        data_addr = 32'h0000_2000;
        drive(1, 1, 1, 0, 0);
        cycle();
        drive(1, 0, 0, 1, 32'h1111_2222);
        cycle();
        drive(1, 0, 1, 0, 0);
        #1;
        check("t2_inst_addr_ok", {63'h0, inst_addr_ok}, 64'h1);
        check("t2_mem_addr", {32'h0, mem_addr}, {32'h0, 32'hBFC0_0000});
        cycle();
        drive(0, 0, 0, 1, 32'h3333_4444);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();

        // Grant lock while data request arrives
        drive(1, 0, 0, 0, 0);
        cycle();
        for (int i = 1; i < 3; i++) begin
            drive(1, 1, 0, 0, 0);
            #1;
            check("t3_locked_addr", {32'h0, mem_addr}, {32'h0, 32'hBFC0_0000});
            cycle();
        end
        drive(1, 1, 1, 0, 0);
        #1;
        check("t3_inst_addr_ok", {62'h0, inst_addr_ok, data_addr_ok}, 64'h2);
        cycle();
        drive(0, 1, 0, 1, 32'h5555_6666);
        cycle();
        drive(0, 1, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 32'h7777_8888);
        cycle();

        // Spurious response in IDLE
        drive(0, 0, 0, 1, 32'h1234_5678);
        #1;
        check("t4_spurious", {30'h0, inst_data_ok, data_data_ok, inst_rdata | data_rdata}, 64'h0);
        cycle();

        // Reset while waiting for data
        drive(0, 1, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        reset = 1;
        cycle();
        reset = 0;
        #1;
        check("t5_busy_after_reset", {63'h0, arb_busy}, 64'h0);
        drive(0, 0, 0, 1, 32'hCAFE_F00D);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();

        // Both held, single-cycle slave
        grants.delete();
        drive(1, 1, 1, 1, 32'hABCD_0000);
        for (int i = 0; i < 14; i++) cycle();
`ifdef ARB_STARVE_GUARD_EN
        exp_g = '{1, 1, 1, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1, 1, 1};
`endif
        for (int i = 0; i < 6; i++)
            check("t6_grant_order", (grants.size() > i) ? 64'(grants[i]) : 64'd9, 64'(exp_g[i]));
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();

        // Random traffic, including dropped requests and resets
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            inst_req   = ($urandom_range(0, 3) != 0);
            data_req   = ($urandom_range(0, 2) != 0);
            mem_addr_ok = $urandom_range(0, 1);
            mem_data_ok = $urandom_range(0, 1);
            mem_rdata  = $urandom;
            inst_wr    = $urandom_range(0, 1);
            data_wr    = $urandom_range(0, 1);
            inst_size  = 2'($urandom_range(0, 2));
            data_size  = 2'($urandom_range(0, 2));
            inst_addr  = $urandom;
            data_addr  = $urandom;
            inst_wstrb = 4'($urandom);
            data_wstrb = 4'($urandom);
            inst_wdata = $urandom;
            data_wdata = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
